// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/grant/response bus (master = LSU, slave = memory)
interface mem_stage_lsu_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [3:0] be;
  logic [31:0] wdata;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM-stage load/store unit; pipeline side (req_i/memRW_i/ld_st_sel_i/addr_i/wdata_i -> stall_o/done_o/misalign_o/rdata_o) runs one request/grant/response transaction on the dmem bus
module mem_stage_lsu (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic memRW_i,
  input  logic [2:0] ld_st_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic stall_o,
  output logic done_o,
  output logic misalign_o,
  output logic [31:0] rdata_o,
  mem_stage_lsu_if.master dmem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, next;
  logic we, mis, illegal;
  logic [31:0] addr, wdata, wdata_n, ext;
  logic [3:0] be, be_n;
  logic [1:0] off;
  logic [2:0] sel;
  logic [7:0] b8;
  logic [15:0] h16;
  always_comb begin
    illegal = ld_st_sel_i == 3'b011 || ld_st_sel_i[2:1] == 2'b11 || (memRW_i && ld_st_sel_i[2]) ||
              (ld_st_sel_i[1:0] == 2'b01 && addr_i[0]) || (ld_st_sel_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    be_n = !memRW_i ? 4'b1111 : ld_st_sel_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] :
           ld_st_sel_i[1:0] == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n = ld_st_sel_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} : ld_st_sel_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    b8 = dmem.rdata[{off, 3'b000} +: 8];
    h16 = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    ext = sel[1:0] == 2'b00 ? {{24{b8[7] & ~sel[2]}}, b8} :
          sel[1:0] == 2'b01 ? {{16{h16[15] & ~sel[2]}}, h16} : dmem.rdata;
  end
  always_comb begin
    next = state == IDLE ? (req_i ? (illegal ? DONE : REQ) : IDLE) :
           state == REQ ? (dmem.gnt ? (we ? DONE : WAIT) : REQ) :
           state == WAIT ? (dmem.rvalid ? DONE : WAIT) : IDLE;
    stall_o = req_i && state != DONE;
    done_o = state == DONE;
    misalign_o = state == DONE && mis;
    dmem.req = state == REQ;
  end
  assign dmem.we = we;
  assign dmem.addr = addr;
  assign dmem.be = be;
  assign dmem.wdata = wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      we <= 1'b0;
      mis <= 1'b0;
      addr <= '0;
      wdata <= '0;
      be <= '0;
      off <= '0;
      sel <= '0;
      rdata_o <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_i) begin
        mis <= illegal;
        if (illegal) rdata_o <= '0;
        else begin
          we <= memRW_i;
          addr <= {addr_i[31:2], 2'b00};
          be <= be_n;
          wdata <= wdata_n;
          off <= addr_i[1:0];
          sel <= ld_st_sel_i;
        end
      end
      if (state == WAIT && dmem.rvalid) rdata_o <= ext;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed-vector bench for mem_stage_lsu with a delay-programmable memory responder
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_i = 1'b0;
  logic memRW_i = 1'b0;
  logic [2:0] ld_st_sel_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic stall_o, done_o, misalign_o;
  logic [31:0] rdata_o;
  int n_cmp = 0;
  int n_bad = 0;
  mem_stage_lsu_if dmem ();
  mem_stage_lsu dut (
    .clk(clk),
    .reset(reset),
    .req_i(req_i),
    .memRW_i(memRW_i),
    .ld_st_sel_i(ld_st_sel_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .stall_o(stall_o),
    .done_o(done_o),
    .misalign_o(misalign_o),
    .rdata_o(rdata_o),
    .dmem(dmem.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_mis"}, 32'(misalign_o), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_dreq"}, 32'(dmem.req), 32'd0);
    chk({tag, "_dwe"}, 32'(dmem.we), 32'd0);
    chk({tag, "_daddr"}, dmem.addr, 32'd0);
    chk({tag, "_dbe"}, 32'(dmem.be), 32'd0);
    chk({tag, "_dwdata"}, dmem.wdata, 32'd0);
  endtask
  // gd: REQ cycles without grant; rd: cycles from grant to rvalid (1 = first WAIT cycle).
  // rvalid is driven high with junk data outside WAIT to show it is ignored there.
  task automatic xact(input string tag, input logic rw, input logic [2:0] sel, input logic [31:0] a, wd, rword,
                      input int gd, rd, input logic [3:0] ebe, input logic [31:0] ewd, erd,
                      input int ecyc, input logic emis);
    int cyc = 1;
    int reqc = 0;
    int waitc = 0;
    int stalls = 0;
    logic granted = 1'b0;
    req_i = 1'b1;
    memRW_i = rw;
    ld_st_sel_i = sel;
    addr_i = a;
    wdata_i = wd;
    #1;
    while (!done_o && cyc < 64) begin
      stalls += int'(stall_o);
      dmem.gnt = 1'b0;
      if (dmem.req) begin
        reqc++;
        chk({tag, "_addr"}, dmem.addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, 32'(dmem.be), 32'(ebe));
        chk({tag, "_we"}, 32'(dmem.we), 32'(rw));
        if (rw) chk({tag, "_wdata"}, dmem.wdata, ewd);
        dmem.gnt = reqc > gd;
        dmem.rvalid = 1'b1;
        dmem.rdata = 32'hBAD0BAD0;
        if (reqc > gd) granted = 1'b1;
      end else if (granted) begin
        waitc++;
        dmem.rvalid = waitc >= rd;
        dmem.rdata = waitc >= rd ? rword : 32'hBAD0BAD0;
      end else begin
        dmem.rvalid = 1'b1;
        dmem.rdata = 32'hBAD0BAD0;
      end
      step();
      cyc++;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(ecyc - 1));
    chk({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    chk({tag, "_req_cycles"}, 32'(reqc), emis ? 32'd0 : 32'(gd + 1));
    chk({tag, "_mis"}, 32'(misalign_o), 32'(emis));
    if (!rw || emis) chk({tag, "_rdata"}, rdata_o, erd);
    req_i = 1'b0;
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = '0;
    step();
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask
  initial begin
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata = '0;
    repeat (3) step();
    chk_all_zero("in_reset");
    reset = 1'b0;
    step();
    chk_all_zero("after_reset");
    xact("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 3, 0);
    xact("sb", 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 0, 3, 0);
    xact("sh", 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1, 1, 4'b1100, 32'hABCDABCD, 0, 4, 0);
    xact("lb", 0, 3'b000, 32'h201, 0, 32'h00008000, 0, 1, 4'b1111, 0, 32'hFFFFFF80, 4, 0);
    xact("lbu", 0, 3'b100, 32'h201, 0, 32'h00008000, 0, 1, 4'b1111, 0, 32'h00000080, 4, 0);
    xact("lhu", 0, 3'b101, 32'h202, 0, 32'hBEEF1234, 0, 1, 4'b1111, 0, 32'h0000BEEF, 4, 0);
    xact("lh", 0, 3'b001, 32'h202, 0, 32'hBEEF1234, 0, 1, 4'b1111, 0, 32'hFFFFBEEF, 4, 0);
    xact("lw_mis", 0, 3'b010, 32'h302, 0, 0, 0, 1, 4'b1111, 0, 0, 2, 1);
    xact("lw_slow", 0, 3'b010, 32'h300, 0, 32'h12345678, 3, 2, 4'b1111, 0, 32'h12345678, 8, 0);
    xact("sbu_ill", 1, 3'b100, 32'h100, 32'h11, 0, 0, 1, 4'b1111, 0, 0, 2, 1);
    xact("lh_odd", 0, 3'b001, 32'h203, 0, 0, 0, 1, 4'b1111, 0, 0, 2, 1);
    xact("sel011", 0, 3'b011, 32'h000, 0, 0, 0, 1, 4'b1111, 0, 0, 2, 1);
    xact("lw_pre", 0, 3'b010, 32'h304, 0, 32'h0BADF00D, 0, 1, 4'b1111, 0, 32'h0BADF00D, 4, 0);
    req_i = 1'b1;
    memRW_i = 1'b0;
    ld_st_sel_i = 3'b010;
    addr_i = 32'h400;
    step();
    chk("rst_in_req", 32'(dmem.req), 32'd1);
    dmem.gnt = 1'b1;
    step();
    dmem.gnt = 1'b0;
    chk("rst_in_wait", 32'(dmem.req), 32'd0);
    reset = 1'b1;
    req_i = 1'b0;
    step();
    chk_all_zero("rst_wait");
    reset = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_rvalid_done", 32'(done_o), 32'd0);
    end
    chk("late_rvalid_rdata", rdata_o, 32'd0);
    dmem.rvalid = 1'b0;
    xact("lw_after_rst", 0, 3'b010, 32'h404, 0, 32'hCAFEF00D, 0, 1, 4'b1111, 0, 32'hCAFEF00D, 4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
